ccff_chain_mem: RTL and testbench
=================================

Name: ccff_chain_mem

Overview:
Parametrised configuration-chain memory, the successor to the fixed-size per-mux/LUT shift-chain memories. It is a MEM_SIZE-bit scan chain shifted on prog_clk, with an optional shadow (active) register. Additions over the fixed chains: load-progress counter, chain status FSM, circular readback mode, and a commit-time length check. Instances sit beside routing muxes and LUTs and are daisy-chained head-to-tail across the tile.

Parameters:
MEM_SIZE, 16, number of configuration bits (>=1).
SHADOW, 1, 1 = mem_out driven from a shadow register updated on commit; 0 = mem_out driven directly by the shift stages (legacy transparent behaviour).
CNT_W, $clog2(MEM_SIZE+2), width of bit_cnt (derived; do not override).

Ports:
prog_clk  input  1  configuration clock
prog_reset_n  input  1  asynchronous active-low reset
ccff_head  input  1  serial config data in
ccff_shift_en  input  1  shift one position this cycle
ccff_readback  input  1  when high, the shift input is taken from ccff_tail (circular rotate) instead of ccff_head
ccff_commit  input  1  copy the shift stages into the shadow register; clear the counter
ccff_tail  output  1  last shift stage, sr[MEM_SIZE-1]
mem_out  output  MEM_SIZE  configuration bits
mem_outb  output  MEM_SIZE  bitwise inverse of mem_out
bit_cnt  output  CNT_W  shifts since the last commit/reset, saturating at MEM_SIZE+1
chain_state  output  2  0 EMPTY, 1 LOADING, 2 FULL, 3 OVERRUN
commit_done  output  1  one-cycle pulse after a commit
len_err  output  1  sticky: a commit occurred with bit_cnt != MEM_SIZE

Behaviour:
- Reset (async assert, sync release): sr=0, shadow=0, bit_cnt=0, chain_state=EMPTY, commit_done=0, len_err=0. Consequently mem_out=0, mem_outb=all ones, ccff_tail=0.
- Shift, when ccff_shift_en=1, at the rising edge:
  - sr[0] <= (ccff_readback ? sr[MEM_SIZE-1] : ccff_head)
  - sr[i] <= sr[i-1] for i = 1..MEM_SIZE-1
  - For MEM_SIZE=1, readback holds the value.
- When ccff_shift_en=0, sr holds; ccff_readback is ignored.
- ccff_tail is combinational from sr[MEM_SIZE-1]; it has no extra latency. A bit entering ccff_head appears on ccff_tail after MEM_SIZE shifts.
- Counter: +1 per shift (readback shifts included), saturating at MEM_SIZE+1.
- chain_state is decoded from the registered count:
  - 0 -> EMPTY
  - 1..MEM_SIZE-1 -> LOADING
  - MEM_SIZE -> FULL
  - MEM_SIZE+1 -> OVERRUN
  - Transitions happen only on a shift, a commit, or reset.
- Commit, when ccff_commit=1 at the edge:
  - SHADOW=1: shadow <= pre-edge sr, i.e. register semantics. If shift and commit occur in the same cycle, the shadow captures the value before the shift and the shift still happens.
  - bit_cnt <= (shift_en ? 1 : 0). The same-cycle shift counts toward the next load.
  - commit_done=1 in the following cycle only.
  - len_err <= len_err | (pre-edge bit_cnt != MEM_SIZE). It clears only on reset.
- SHADOW=1: mem_out = shadow, so mem_out changes only one edge after a commit and never during shifting.
- SHADOW=0: mem_out = sr, so it changes on every shift. Commit still updates the counter, commit_done and len_err.
- Readback of a full chain: MEM_SIZE rotate shifts restore sr and stream every bit on ccff_tail, MSB stage first. The counter reads OVERRUN afterwards unless a commit intervenes; this is intended, and the verifier commits or resets after readback.
- Reset mid-load: all progress is discarded and there is no partial commit.

Decomposition:
- Shared package ccff_pkg holds:
  - chain_state encodings CCFF_EMPTY/LOADING/FULL/OVERRUN (2-bit typedef)
  - a function for CNT_W
- One natural sub-module: ccff_chain_stage, a single shift stage with readback mux, instantiated MEM_SIZE times via generate.
- Counter, FSM decode, shadow and error logic stay in the top module.

Test Plan:
- Reset check: assert prog_reset_n=0 asynchronously mid-cycle -> mem_out=0, mem_outb=16'hFFFF, chain_state=0, len_err=0, all immediately.
- Load and commit (MEM_SIZE=16, SHADOW=1): shift in 16'hA5C3 LSB-last over 16 cycles -> chain_state=2, mem_out still 0. Then pulse ccff_commit -> next cycle mem_out=16'hA5C3, commit_done=1 for one cycle, bit_cnt=0, len_err=0.
- Short load: 10 shifts then commit -> len_err=1 and stays 1 through further correct loads until reset. Shifting 17 times -> chain_state=3 (OVERRUN), bit_cnt=17.
- Readback: after loading 16'h8001, 16 shifts with ccff_readback=1 -> ccff_tail emits 1,0×14,1, sr returns to 16'h8001, and ccff_head is ignored (drive it to 1).
- Simultaneous shift+commit: sr=16'h00FF, head=1, shift_en=commit=1 in one cycle -> shadow=16'h00FF, sr=16'h01FF, bit_cnt=1.
- SHADOW=0, MEM_SIZE=2: shift 1 then 0 -> mem_out follows each shift (sr[0]=1, then sr=2'b10, i.e. mem_out[0]=0 and mem_out[1]=1), ccff_tail=1 after the second shift.

Source files
------------

// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain memory: status encodings
// and the counter-width helper used by the top-level parameter list.
package ccff_pkg;

    typedef enum logic [1:0] {
        CCFF_EMPTY   = 2'd0,
        CCFF_LOADING = 2'd1,
        CCFF_FULL    = 2'd2,
        CCFF_OVERRUN = 2'd3
    } ccff_state_e;

    // Counter must hold 0..MEM_SIZE+1 so that overrun is distinguishable from full.
    function automatic int ccff_cnt_w(input int mem_size);
        return $clog2(mem_size + 2);
    endfunction

endpackage

// File: rtl/ccff_chain_stage.sv
// One bit of the configuration scan chain. The stage loads either its serial
// neighbour or the loop-back input (used only by stage 0 for circular readback).
module ccff_chain_stage (
    input  logic prog_clk,
    input  logic prog_reset_n,
    input  logic shift_en,
    input  logic serial_in,
    input  logic loop_in,
    input  logic readback,
    output logic q
);

    logic q_d;
    logic q_q;

    // Next-state select: hold, take serial neighbour, or take loop-back bit.
    always_comb begin
        q_d = q_q;
        if (shift_en) begin
            if (readback) begin
                q_d = loop_in;
            end else begin
                q_d = serial_in;
            end
        end else begin
            q_d = q_q;
        end
    end

    // Stage flop, cleared asynchronously.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ccff_chain_mem.sv
// Parametrised configuration-chain memory: MEM_SIZE-bit scan chain with an
// optional shadow register, load-progress counter, status decode, circular
// readback and a sticky length check evaluated at commit time.
module ccff_chain_mem
    import ccff_pkg::*;
#(
    parameter int MEM_SIZE = 16,
    parameter int SHADOW   = 1,
    parameter int CNT_W    = ccff_cnt_w(MEM_SIZE)
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic                ccff_head,
    input  logic                ccff_shift_en,
    input  logic                ccff_readback,
    input  logic                ccff_commit,
    output logic                ccff_tail,
    output logic [MEM_SIZE-1:0] mem_out,
    output logic [MEM_SIZE-1:0] mem_outb,
    output logic [CNT_W-1:0]    bit_cnt,
    output logic [1:0]          chain_state,
    output logic                commit_done,
    output logic                len_err
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MEM_SIZE);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MEM_SIZE + 1);

    logic [MEM_SIZE-1:0] sr_s;
    logic [CNT_W-1:0]    bit_cnt_d;
    logic [CNT_W-1:0]    bit_cnt_q;
    ccff_state_e         state_d;
    ccff_state_e         state_q;
    logic                commit_done_d;
    logic                commit_done_q;
    logic                len_err_d;
    logic                len_err_q;

    // Shift stages; stage 0 carries the head/readback mux, the rest chain directly.
    for (genvar i = 0; i < MEM_SIZE; i++) begin : g_stage
        if (i == 0) begin : g_first
            ccff_chain_stage u_stage (
                .prog_clk     (prog_clk),
                .prog_reset_n (prog_reset_n),
                .shift_en     (ccff_shift_en),
                .serial_in    (ccff_head),
                .loop_in      (sr_s[MEM_SIZE-1]),
                .readback     (ccff_readback),
                .q            (sr_s[0])
            );
        end else begin : g_rest
            ccff_chain_stage u_stage (
                .prog_clk     (prog_clk),
                .prog_reset_n (prog_reset_n),
                .shift_en     (ccff_shift_en),
                .serial_in    (sr_s[i-1]),
                .loop_in      (sr_s[i-1]),
                .readback     (1'b0),
                .q            (sr_s[i])
            );
        end
    end

    // Progress counter: a commit restarts it (a same-cycle shift counts toward
    // the next load); otherwise shifts increment it up to the overrun value.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (ccff_commit) begin
            bit_cnt_d = ccff_shift_en ? CNT_ONE : CNT_ZERO;
        end else if (ccff_shift_en && (bit_cnt_q != CNT_SAT)) begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Status decode of the next count so the registered state tracks bit_cnt.
    always_comb begin
        state_d = CCFF_EMPTY;
        if (bit_cnt_d == CNT_ZERO) begin
            state_d = CCFF_EMPTY;
        end else if (bit_cnt_d < CNT_FULL) begin
            state_d = CCFF_LOADING;
        end else if (bit_cnt_d == CNT_FULL) begin
            state_d = CCFF_FULL;
        end else begin
            state_d = CCFF_OVERRUN;
        end
    end

    // Commit pulse and sticky length error, judged on the pre-edge count.
    always_comb begin
        commit_done_d = ccff_commit;
        len_err_d     = len_err_q | (ccff_commit & (bit_cnt_q != CNT_FULL));
    end

    // Status registers.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            bit_cnt_q     <= CNT_ZERO;
            state_q       <= CCFF_EMPTY;
            commit_done_q <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            state_q       <= state_d;
            commit_done_q <= commit_done_d;
            len_err_q     <= len_err_d;
        end
    end

    if (SHADOW != 0) begin : g_shadow
        logic [MEM_SIZE-1:0] shadow_d;
        logic [MEM_SIZE-1:0] shadow_q;

        // Shadow captures the pre-shift chain contents on commit.
        always_comb begin
            if (ccff_commit) begin
                shadow_d = sr_s;
            end else begin
                shadow_d = shadow_q;
            end
        end

        // Shadow (active configuration) register.
        always_ff @(posedge prog_clk or negedge prog_reset_n) begin
            if (!prog_reset_n) begin
                shadow_q <= {MEM_SIZE{1'b0}};
            end else begin
                shadow_q <= shadow_d;
            end
        end

        assign mem_out = shadow_q;
    end else begin : g_transparent
        assign mem_out = sr_s;
    end

    assign mem_outb    = ~mem_out;
    assign ccff_tail   = sr_s[MEM_SIZE-1];
    assign bit_cnt     = bit_cnt_q;
    assign chain_state = state_q;
    assign commit_done = commit_done_q;
    assign len_err     = len_err_q;

endmodule

// File: tb/tb_ccff_chain_mem.sv
// Self-checking bench for ccff_chain_mem: a shadowed 16-bit chain driven
// through a constant-vector table and model-driven sequences, plus a
// transparent 2-bit chain exercised by hand.
module tb_ccff_chain_mem;
    import ccff_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        head, shift, rb, commit;
    logic        tail;
    logic [15:0] mem, memb;
    logic [4:0]  cnt;
    logic [1:0]  st;
    logic        cd, le;

    logic        head2, shift2, commit2;
    logic        tail2;
    logic [1:0]  mem2, memb2;
    logic [1:0]  cnt2;
    logic [1:0]  st2;
    logic        cd2, le2;

    ccff_chain_mem #(.MEM_SIZE(16), .SHADOW(1)) u_dut (
        .prog_clk(clk), .prog_reset_n(rst_n), .ccff_head(head),
        .ccff_shift_en(shift), .ccff_readback(rb), .ccff_commit(commit),
        .ccff_tail(tail), .mem_out(mem), .mem_outb(memb), .bit_cnt(cnt),
        .chain_state(st), .commit_done(cd), .len_err(le)
    );

    ccff_chain_mem #(.MEM_SIZE(2), .SHADOW(0)) u_dut2 (
        .prog_clk(clk), .prog_reset_n(rst_n), .ccff_head(head2),
        .ccff_shift_en(shift2), .ccff_readback(1'b0), .ccff_commit(commit2),
        .ccff_tail(tail2), .mem_out(mem2), .mem_outb(memb2), .bit_cnt(cnt2),
        .chain_state(st2), .commit_done(cd2), .len_err(le2)
    );

    typedef struct {
        logic [15:0] mem;
        logic        tail;
        logic [4:0]  cnt;
        logic [1:0]  st;
        logic        cd;
        logic        le;
    } exp_t;

    typedef struct {
        bit   h, s, r, c;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   total = 0;
    int   bad   = 0;

    // Behavioural model of the shadowed 16-bit chain.
    logic [15:0] m_sr, m_sh;
    int          m_cnt;
    bit          m_le;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] st_of(input int c);
        if (c == 0) return 2'd0;
        else if (c < 16) return 2'd1;
        else if (c == 16) return 2'd2;
        else return 2'd3;
    endfunction

    // Drive one cycle, push its expectation, then pop and compare after the edge.
    task automatic drive_cycle(input bit h, input bit s, input bit r, input bit c, input exp_t e);
        exp_t        g;
        logic [15:0] inv;
        @(negedge clk);
        head = h; shift = s; rb = r; commit = c;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g   = sb.pop_front();
        inv = ~g.mem;
        chk("mem_out", mem, g.mem);
        chk("mem_outb", memb, inv);
        chk("tail", tail, g.tail);
        chk("bit_cnt", cnt, g.cnt);
        chk("chain_state", st, g.st);
        chk("commit_done", cd, g.cd);
        chk("len_err", le, g.le);
    endtask

    // Advance the model by one cycle and check the DUT against it.
    task automatic step_m(input bit h, input bit s, input bit r, input bit c);
        logic [15:0] pre_sr;
        int          pre_cnt;
        exp_t        e;
        pre_sr  = m_sr;
        pre_cnt = m_cnt;
        if (s) m_sr = {m_sr[14:0], (r ? m_sr[15] : h)};
        if (c) begin
            m_sh  = pre_sr;
            m_cnt = s ? 1 : 0;
            if (pre_cnt != 16) m_le = 1'b1;
        end else if (s && m_cnt < 17) begin
            m_cnt = m_cnt + 1;
        end
        e = '{mem: m_sh, tail: m_sr[15], cnt: 5'(m_cnt), st: st_of(m_cnt), cd: c, le: m_le};
        drive_cycle(h, s, r, c, e);
    endtask

    task automatic load16(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) step_m(v[i], 1'b1, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        head = 1'b0; shift = 1'b0; rb = 1'b0; commit = 1'b0;
        head2 = 1'b0; shift2 = 1'b0; commit2 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mem_out", mem, 32'h0000);
        chk("rst_mem_outb", memb, 32'hFFFF);
        chk("rst_state", st, 32'd0);
        chk("rst_len_err", le, 32'd0);
        chk("rst_bit_cnt", cnt, 32'd0);
        chk("rst_tail", tail, 32'd0);
        chk("rst_commit_done", cd, 32'd0);
        m_sr = 16'h0000; m_sh = 16'h0000; m_cnt = 0; m_le = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        head = 1'b0; shift = 1'b0; rb = 1'b0; commit = 1'b0;
        head2 = 1'b0; shift2 = 1'b0; commit2 = 1'b0;
        m_sr = 16'h0000; m_sh = 16'h0000; m_cnt = 0; m_le = 1'b0;

        tbl[0] = '{h:1'b1, s:1'b1, r:1'b0, c:1'b0, e:'{16'h0000, 1'b0, 5'd1, 2'd1, 1'b0, 1'b0}};
        tbl[1] = '{h:1'b0, s:1'b0, r:1'b0, c:1'b0, e:'{16'h0000, 1'b0, 5'd1, 2'd1, 1'b0, 1'b0}};
        tbl[2] = '{h:1'b0, s:1'b0, r:1'b0, c:1'b1, e:'{16'h0001, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1}};
        tbl[3] = '{h:1'b0, s:1'b0, r:1'b0, c:1'b0, e:'{16'h0001, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1}};
        tbl[4] = '{h:1'b0, s:1'b1, r:1'b0, c:1'b1, e:'{16'h0001, 1'b0, 5'd1, 2'd1, 1'b1, 1'b1}};
        tbl[5] = '{h:1'b0, s:1'b0, r:1'b0, c:1'b1, e:'{16'h0002, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1}};
        tbl[6] = '{h:1'b1, s:1'b1, r:1'b1, c:1'b0, e:'{16'h0002, 1'b0, 5'd1, 2'd1, 1'b0, 1'b1}};
        tbl[7] = '{h:1'b0, s:1'b0, r:1'b0, c:1'b1, e:'{16'h0004, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1}};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Constant-vector table.
        for (int i = 0; i < 8; i++) drive_cycle(tbl[i].h, tbl[i].s, tbl[i].r, tbl[i].c, tbl[i].e);

        // Mid-cycle async reset with a non-zero shadow in place.
        do_reset();

        // Full load and commit.
        load16(16'hA5C3);
        chk("load_state_full", st, 32'd2);
        chk("load_mem_hidden", mem, 32'h0000);
        step_m(1'b0, 1'b0, 1'b0, 1'b1);
        chk("commit_mem", mem, 32'hA5C3);
        chk("commit_pulse", cd, 32'd1);
        chk("commit_cnt", cnt, 32'd0);
        chk("commit_len_ok", le, 32'd0);
        step_m(1'b0, 1'b0, 1'b0, 1'b0);
        chk("commit_pulse_end", cd, 32'd0);

        // Short load sets the sticky error; a good load does not clear it.
        for (int i = 0; i < 10; i++) step_m(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        step_m(1'b0, 1'b0, 1'b0, 1'b1);
        chk("short_len_err", le, 32'd1);
        load16(16'h1234);
        step_m(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sticky_len_err", le, 32'd1);
        chk("good_mem", mem, 32'h1234);
        for (int i = 0; i < 17; i++) step_m(1'b1, 1'b1, 1'b0, 1'b0);
        chk("overrun_state", st, 32'd3);
        chk("overrun_cnt", cnt, 32'd17);
        step_m(1'b0, 1'b1, 1'b0, 1'b0);
        step_m(1'b1, 1'b1, 1'b0, 1'b0);
        chk("sat_cnt", cnt, 32'd17);
        do_reset();

        // Circular readback of 16'h8001 with head held high.
        load16(16'h8001);
        for (int j = 0; j < 16; j++) begin
            chk("rb_tail", tail, ((j == 0) || (j == 15)) ? 32'd1 : 32'd0);
            step_m(1'b1, 1'b1, 1'b1, 1'b0);
        end
        step_m(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rb_restored", mem, 32'h8001);
        do_reset();

        // Shift and commit in the same cycle.
        load16(16'h00FF);
        step_m(1'b1, 1'b1, 1'b0, 1'b1);
        chk("simul_shadow", mem, 32'h00FF);
        chk("simul_cnt", cnt, 32'd1);
        step_m(1'b0, 1'b0, 1'b0, 1'b1);
        chk("simul_sr", mem, 32'h01FF);
        do_reset();

        // Transparent 2-bit chain.
        @(negedge clk); head2 = 1'b1; shift2 = 1'b1;
        @(posedge clk); #1;
        chk("t2_mem_a", mem2, 32'd1);
        chk("t2_tail_a", tail2, 32'd0);
        chk("t2_state_a", st2, 32'd1);
        @(negedge clk); head2 = 1'b0; shift2 = 1'b1;
        @(posedge clk); #1;
        chk("t2_mem_b", mem2, 32'd2);
        chk("t2_memb_b", memb2, 32'd1);
        chk("t2_tail_b", tail2, 32'd1);
        chk("t2_state_b", st2, 32'd2);
        chk("t2_cnt_b", cnt2, 32'd2);
        @(negedge clk); head2 = 1'b0; shift2 = 1'b1;
        @(posedge clk); #1;
        chk("t2_state_c", st2, 32'd3);
        chk("t2_cnt_c", cnt2, 32'd3);
        @(negedge clk); shift2 = 1'b0; commit2 = 1'b1;
        @(posedge clk); #1;
        chk("t2_commit_done", cd2, 32'd1);
        chk("t2_cnt_d", cnt2, 32'd0);
        chk("t2_len_err", le2, 32'd1);
        chk("t2_mem_d", mem2, 32'd0);
        @(negedge clk); commit2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
